// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: PC sequencing, single-entry instruction register and field decode.
// Optional retired-instruction counter enabled by defining INSTR_FETCH_INSTR_CNT_EN.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        Clk,
  input  logic        Rst,
  output logic        IMemReq,
  output logic [31:0] IMemAddr,
  input  logic        IMemReady,
  input  logic [31:0] IMemData,
  input  logic        Redirect,
  input  logic [31:0] RedirectPC,
  input  logic        Stall,
  output logic        Valid,
  output logic [31:0] Instr,
  output logic [31:0] InstrPC,
  output logic [4:0]  RR1,
  output logic [4:0]  RR2,
  output logic [4:0]  WR,
  output logic [4:0]  ShiftCount,
  output logic [5:0]  Funct,
  output logic [31:0] Imm
`ifdef INSTR_FETCH_INSTR_CNT_EN
  ,
  output logic [31:0] InstrCount
`endif
);

  localparam int unsigned XLEN     = 32;
  localparam int unsigned IMM_W    = 16;
  localparam logic [XLEN-1:0] ALIGN_MASK = 32'hFFFF_FFFC;
  localparam logic [XLEN-1:0] RESET_PC_ALIGNED = RESET_PC & ALIGN_MASK;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic              valid_q, valid_d;
  logic [XLEN-1:0]   instr_q, instr_d;
  logic [XLEN-1:0]   instr_pc_q, instr_pc_d;
  logic              consume;
  logic              capture;
`ifdef INSTR_FETCH_INSTR_CNT_EN
  logic [XLEN-1:0]   cnt_q, cnt_d;
`endif

  // Next-state and datapath update; Redirect takes priority over everything but reset.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    valid_d    = valid_q;
    instr_d    = instr_q;
    instr_pc_d = instr_pc_q;
    capture    = 1'b0;
    consume    = valid_q && !Stall;

    unique case (state_q)
      IDLE:  state_d = FETCH;
      FETCH: begin
        if (valid_q && Stall) begin
          state_d = HOLD;
        end else if (IMemReady && !Redirect) begin
          capture = 1'b1;
        end
      end
      HOLD:  if (!Stall) state_d = FETCH;
      default: state_d = IDLE;
    endcase

    if (consume && !capture) valid_d = 1'b0;

    if (capture) begin
      instr_d    = IMemData;
      instr_pc_d = pc_q;
      valid_d    = 1'b1;
      pc_d       = pc_q + XLEN'(4);
    end

    if (Redirect) begin
      pc_d    = RedirectPC & ALIGN_MASK;
      valid_d = 1'b0;
      state_d = FETCH;
    end
  end

`ifdef INSTR_FETCH_INSTR_CNT_EN
  always_comb begin
    cnt_d = cnt_q;
    if (consume) cnt_d = cnt_q + XLEN'(1);
  end
`endif

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC_ALIGNED;
      valid_q    <= 1'b0;
      instr_q    <= '0;
      instr_pc_q <= '0;
`ifdef INSTR_FETCH_INSTR_CNT_EN
      cnt_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      valid_q    <= valid_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
`ifdef INSTR_FETCH_INSTR_CNT_EN
      cnt_q      <= cnt_d;
`endif
    end
  end

  // Request is masked by Rst so nothing is issued while reset is held.
  assign IMemReq  = (state_q == FETCH) && !Rst;
  assign IMemAddr = pc_q;
  assign Valid    = valid_q;
  assign Instr    = instr_q;
  assign InstrPC  = instr_pc_q;
`ifdef INSTR_FETCH_INSTR_CNT_EN
  assign InstrCount = cnt_q;
`endif

  assign RR1        = instr_q[25:21];
  assign RR2        = instr_q[20:16];
  assign WR         = instr_q[15:11];
  assign ShiftCount = instr_q[10:6];
  assign Funct      = instr_q[5:0];
  assign Imm        = {{(XLEN-IMM_W){instr_q[IMM_W-1]}}, instr_q[IMM_W-1:0]};

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Randomized self-checking bench for instr_fetch_unit against a transaction-level model.
module tb_instr_fetch_unit;

  logic        Clk = 1'b0;
  logic        Rst;
  logic        IMemReq;
  logic [31:0] IMemAddr;
  logic        IMemReady;
  logic [31:0] IMemData;
  logic        Redirect;
  logic [31:0] RedirectPC;
  logic        Stall;
  logic        Valid;
  logic [31:0] Instr;
  logic [31:0] InstrPC;
  logic [4:0]  RR1, RR2, WR, ShiftCount;
  logic [5:0]  Funct;
  logic [31:0] Imm;
`ifdef INSTR_FETCH_INSTR_CNT_EN
  logic [31:0] InstrCount;
  logic [31:0] w_cnt;
`endif

  logic        w_req, w_valid;
  logic [31:0] w_addr, w_instr, w_ipc, w_imm;
  logic [4:0]  w_rr1, w_rr2, w_wr, w_sh;
  logic [5:0]  w_funct;

  always #5 Clk = ~Clk;

  instr_fetch_unit dut (
    .Clk(Clk), .Rst(Rst), .IMemReq(IMemReq), .IMemAddr(IMemAddr),
    .IMemReady(IMemReady), .IMemData(IMemData), .Redirect(Redirect),
    .RedirectPC(RedirectPC), .Stall(Stall), .Valid(Valid), .Instr(Instr),
    .InstrPC(InstrPC), .RR1(RR1), .RR2(RR2), .WR(WR), .ShiftCount(ShiftCount),
    .Funct(Funct), .Imm(Imm)
`ifdef INSTR_FETCH_INSTR_CNT_EN
    , .InstrCount(InstrCount)
`endif
  );

  // Second instance exercises a misaligned reset PC right at the wrap point.
  instr_fetch_unit #(.RESET_PC(32'hFFFF_FFFF)) dut_w (
    .Clk(Clk), .Rst(Rst), .IMemReq(w_req), .IMemAddr(w_addr),
    .IMemReady(1'b1), .IMemData(32'h0), .Redirect(1'b0),
    .RedirectPC(32'h0), .Stall(1'b0), .Valid(w_valid), .Instr(w_instr),
    .InstrPC(w_ipc), .RR1(w_rr1), .RR2(w_rr2), .WR(w_wr), .ShiftCount(w_sh),
    .Funct(w_funct), .Imm(w_imm)
`ifdef INSTR_FETCH_INSTR_CNT_EN
    , .InstrCount(w_cnt)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Model: m_req says whether the unit is asking memory this cycle; when not
  // asking, a held instruction (m_valid) means it is waiting out a stall.
  logic [31:0] m_pc, m_instr, m_ipc, m_cnt;
  bit          m_valid, m_req;
  bit          armed = 1'b0;

  task automatic model_step();
    if (Rst) begin
      m_pc = 32'h0; m_valid = 0; m_instr = 0; m_ipc = 0; m_cnt = 0; m_req = 0;
    end else begin
      if (m_valid && !Stall) m_cnt = m_cnt + 1;
      if (Redirect) begin
        m_pc = RedirectPC & 32'hFFFF_FFFC; m_valid = 0; m_req = 1;
      end else if (!m_req) begin
        if (!m_valid || !Stall) begin m_valid = 0; m_req = 1; end
      end else if (m_valid && Stall) begin
        m_req = 0;
      end else if (IMemReady) begin
        m_instr = IMemData; m_ipc = m_pc; m_valid = 1; m_pc = m_pc + 4;
      end else begin
        m_valid = 0;
      end
    end
  endtask

  task automatic compare_all();
    logic [31:0] exp_imm;
    exp_imm = (m_instr & 32'h8000) != 0 ? (m_instr | 32'hFFFF_0000) : (m_instr & 32'h0000_FFFF);
    check("imem_req", 32'(IMemReq), 32'(m_req && !Rst));
    check("imem_addr", IMemAddr, m_pc);
    check("valid", 32'(Valid), 32'(m_valid));
    check("instr", Instr, m_instr);
    check("instr_pc", InstrPC, m_ipc);
    check("rr1", 32'(RR1), (m_instr >> 21) % 32);
    check("rr2", 32'(RR2), (m_instr >> 16) % 32);
    check("wr", 32'(WR), (m_instr >> 11) % 32);
    check("shamt", 32'(ShiftCount), (m_instr >> 6) % 32);
    check("funct", 32'(Funct), m_instr % 64);
    check("imm", Imm, exp_imm);
`ifdef INSTR_FETCH_INSTR_CNT_EN
    check("instr_count", InstrCount, m_cnt);
`endif
  endtask

  // One clock: drive at posedge+1, compare before the edge, advance the model on the edge.
  task automatic cycle(input bit rst, input bit rdy, input logic [31:0] data,
                       input bit redir, input logic [31:0] rpc, input bit stall);
    Rst = rst; IMemReady = rdy; IMemData = data;
    Redirect = redir; RedirectPC = rpc; Stall = stall;
    #1;
    if (armed) compare_all();
    @(posedge Clk);
    model_step();
    armed = 1'b1;
    #1;
  endtask

  logic [31:0] held_pc;

  initial begin
    cycle(1, 0, 32'h0, 0, 32'h0, 0);
    cycle(1, 1, 32'h1234_5678, 1, 32'h40, 0);
    check("w_reset_pc", w_addr, 32'hFFFF_FFFC);
    check("w_reset_valid", 32'(w_valid), 32'h0);
`ifdef INSTR_FETCH_INSTR_CNT_EN
    check("reset_count", InstrCount, 32'h0);
`endif

    // Streaming fetch with data equal to address
    for (int k = 1; k <= 6; k++) begin
      cycle(0, 1, m_pc, 0, 32'h0, 0);
      check("stream_addr", IMemAddr, 32'(k - 1) * 4);
      if (k == 1) check("w_first_addr", w_addr, 32'hFFFF_FFFC);
      if (k == 2) begin
        check("w_wrap_addr", w_addr, 32'h0);
        check("w_wrap_ipc", w_ipc, 32'hFFFF_FFFC);
        check("stream_first_valid", 32'(Valid), 32'h1);
      end
      if (k >= 2) check("stream_ipc_tracks", InstrPC, Instr);
    end

    // Field decode
    cycle(0, 1, 32'h0085_18A2, 0, 32'h0, 0);
    check("dec_rr1", 32'(RR1), 32'd4);
    check("dec_rr2", 32'(RR2), 32'd5);
    check("dec_wr", 32'(WR), 32'd3);
    check("dec_shamt", 32'(ShiftCount), 32'd2);
    check("dec_funct", 32'(Funct), 32'h22);
    cycle(0, 1, 32'h2001_FFFE, 0, 32'h0, 0);
    check("dec_imm", Imm, 32'hFFFF_FFFE);

    // Stall for three cycles, then release
    held_pc = m_ipc;
    for (int k = 0; k < 3; k++) begin
      cycle(0, 1, 32'hDEAD_0000 + 32'(k), 0, 32'h0, 1);
      check("hold_req", 32'(IMemReq), 32'h0);
      check("hold_instr", Instr, 32'h2001_FFFE);
      check("hold_valid", 32'(Valid), 32'h1);
    end
    cycle(0, 1, 32'hDEAD_BEEF, 0, 32'h0, 0);
    check("release_valid", 32'(Valid), 32'h0);
    check("release_addr", IMemAddr, held_pc + 4);
    cycle(0, 1, 32'h1111_2222, 0, 32'h0, 0);
    check("refetch_ipc", InstrPC, held_pc + 4);

    // Redirect coinciding with a response
    cycle(0, 1, 32'hBAD0_BAD0, 1, 32'h0000_0102, 0);
    check("redir_valid", 32'(Valid), 32'h0);
    check("redir_addr", IMemAddr, 32'h0000_0100);
    check("redir_req", 32'(IMemReq), 32'h1);

    // Reset while holding, with a competing redirect
    cycle(0, 1, 32'h3333_4444, 0, 32'h0, 0);
    cycle(0, 1, 32'h5555_6666, 0, 32'h0, 1);
    check("pre_rst_hold_req", 32'(IMemReq), 32'h0);
    cycle(1, 1, 32'h7777_8888, 1, 32'h0000_0200, 1);
    check("rst_hold_valid", 32'(Valid), 32'h0);
    check("rst_hold_pc", IMemAddr, 32'h0);
    check("rst_hold_req", 32'(IMemReq), 32'h0);

    // Randomized traffic
    for (int n = 0; n < 4000; n++) begin
      logic [31:0] rpc;
      rpc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
      cycle($urandom_range(0, 99) == 0,
            $urandom_range(0, 9) < 6,
            $urandom,
            $urandom_range(0, 19) == 0,
            rpc,
            $urandom_range(0, 9) < 3);
    end
    cycle(0, 0, 32'h0, 0, 32'h0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 The block SHALL take the parameter RESET_PC, default 32'h0000_0000, as the PC value loaded at reset, with bits [1:0] forced to 0.
REQ-002 Clk  input  1  rising-edge clock for all state.
REQ-003 Rst  input  1  reset, synchronous, active-high.
REQ-004 IMemReq  output  1  instruction-memory read request.
REQ-005 IMemAddr  output  32  word-aligned read address, always equal to the internal PC.
REQ-006 IMemReady  input  1  memory response valid; sampled only while IMemReq=1.
REQ-007 IMemData  input  32  instruction word; valid when IMemReady=1.
REQ-008 Redirect  input  1  branch/jump taken; loads the PC from RedirectPC.
REQ-009 RedirectPC  input  32  redirect target address.
REQ-010 Stall  input  1  downstream (decode/register file) cannot accept the held instruction.
REQ-011 Valid  output  1  Instr and all decoded fields are valid.
REQ-012 Instr  output  32  instruction register.
REQ-013 InstrPC  output  32  address Instr was fetched from.
REQ-014 RR1  output  5  Instr[25:21] (rs), driving the register file read port 1.
REQ-015 RR2  output  5  Instr[20:16] (rt), driving the register file read port 2.
REQ-016 WR  output  5  Instr[15:11] (rd).
REQ-017 ShiftCount  output  5  Instr[10:6] (shamt), driving the ALU shift amount.
REQ-018 Funct  output  6  Instr[5:0].
REQ-019 Imm  output  32  Instr[15:0] sign-extended to 32 bits.
REQ-020 InstrCount  output  32  count of retired fetches; present only when the Configuration macro is defined.

Function
REQ-021 The FSM SHALL have exactly three states: IDLE, FETCH and HOLD.
REQ-022 IDLE: IMemReq=0; the FSM SHALL go to FETCH on the next cycle unconditionally.
REQ-023 FETCH: IMemReq=1 and IMemAddr=PC.
- On IMemReady=1 with (Valid=0 or Stall=0), the block SHALL load Instr<=IMemData, InstrPC<=PC and Valid<=1, and advance PC<=PC+4.
REQ-024 FETCH with Valid=1, Stall=1 and IMemReady=0: the FSM SHALL go to HOLD with no capture.
REQ-025 FETCH with Valid=1, Stall=1 and IMemReady=1: the block SHALL discard the response, leave PC unchanged and go to HOLD.
REQ-026 HOLD: IMemReq=0 and Instr/Valid SHALL be held; when Stall=0 the block SHALL drop Valid and return to FETCH.
REQ-027 Handshake: an instruction SHALL be consumed on any cycle with Valid=1 and Stall=0.
- A consumed instruction SHALL not be presented again unless refetched.
- If Valid=1, Stall=0 and there is no capture that cycle, Valid SHALL go to 0.
REQ-028 PC increment SHALL wrap modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000).
REQ-029 Redirect=1 SHALL override all other events in that cycle:
- PC<=RedirectPC with bits [1:0] forced to 0.
- Valid<=0 and any same-cycle memory response discarded.
- State<=FETCH, from any state including HOLD.
REQ-030 Decoded outputs SHALL be combinational functions of Instr only, and stay stable while Valid=1 and Stall=1.
REQ-031 Latency: the first IMemReq SHALL occur 1 cycle after Rst deasserts; Valid SHALL rise 1 cycle after the IMemReady cycle.

Reset
REQ-032 On Rst=1 at a rising edge the block SHALL set:
- PC=RESET_PC and state=IDLE.
- Valid=0, Instr=0 and InstrPC=0.
- InstrCount=0 when present.
REQ-033 Rst SHALL override Redirect and any in-flight response, including mid-FETCH and mid-HOLD.
REQ-034 While Rst=1, IMemReq SHALL be 0.

Configuration
REQ-035 With macro INSTR_FETCH_INSTR_CNT_EN defined, the block SHALL provide the InstrCount port, counting consumed instructions (REQ-027) and wrapping at 2^32.
- Redirect-discarded responses SHALL not be counted.
REQ-036 Without INSTR_FETCH_INSTR_CNT_EN, the port and the counter logic SHALL be absent, with all other behaviour identical.

Verification
REQ-037 Reset, then memory always ready with IMemData=addr, Stall=0 -> IMemAddr sequence 0,4,8; Valid continuous from the 3rd cycle; InstrPC tracks Instr.
REQ-038 Instr=32'h0085_18A2 -> RR1=4, RR2=5, WR=3, ShiftCount=2, Funct=6'h22; Instr=32'h2001_FFFE -> Imm=32'hFFFF_FFFE.
REQ-039 Stall=1 for 3 cycles while Valid=1 -> Instr held, IMemReq=0 in HOLD; Stall=0 -> next fetch at InstrPC+4; no instruction skipped or duplicated.
REQ-040 Redirect=1, RedirectPC=32'h0000_0102, in the same cycle as IMemReady=1 -> response dropped, Valid=0 next cycle, next IMemAddr=32'h0000_0100.
REQ-041 RESET_PC=32'hFFFF_FFFC -> second fetch address 32'h0000_0000; Rst asserted mid-HOLD -> Valid=0 and PC=RESET_PC next cycle; with INSTR_FETCH_INSTR_CNT_EN defined, InstrCount=0 after reset.
